ram512_seq: RTL and testbench
=============================

RAM512_SEQ -- requirements
Module: ram512_seq

Interface
REQ-001 Parameters SHALL be: DATA_W, 16, word width; ADDR_W, 9, RAM address width (512 words).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  command strobe, sampled only in IDLE.
REQ-005 mode  input  2  00 fill-constant, 01 fill-increment, 10 scan-sum, 11 reserved.
REQ-006 base  input  9  first RAM address of the operation.
REQ-007 count  input  10  number of words, legal range 1..512.
REQ-008 pattern  input  16  fill value, or start value for fill-increment.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse on completion, including error completion.
REQ-011 err  output  1  one-cycle pulse, coincident with done, for an illegal command.
REQ-012 checksum  output  16  scan-sum result, held until the next accepted scan.
REQ-013 mem_in  output  16  write data to RAM512.
REQ-014 mem_address  output  9  address to RAM512.
REQ-015 mem_load  output  1  write enable to RAM512.
REQ-016 mem_out  input  16  RAM512 read data, combinational from mem_address.

Function
REQ-017 States SHALL be IDLE, FILL, SCAN and FIN.
REQ-018 In IDLE, start=1 SHALL latch mode, base, count and pattern, then transition as follows:
- FILL for mode 00 or 01.
- SCAN for mode 10.
- FIN with err for mode 11, count=0 or count>512.
REQ-019 busy SHALL be 1 in FILL, SCAN and FIN, and 0 in IDLE; start while busy SHALL be ignored.
REQ-020 mem_in, mem_address and mem_load SHALL be registered outputs.
REQ-021 FILL SHALL assert mem_load for exactly count consecutive cycles, starting the cycle after start is accepted.
REQ-022 FILL SHALL present address (base+i) mod 512 on cycle i.
REQ-023 FILL data on cycle i SHALL be pattern for mode 00, and (pattern+i) mod 2^16 for mode 01.
REQ-024 SCAN SHALL hold mem_load=0 and present address (base+i) mod 512 on cycle i.
REQ-025 SCAN SHALL add mem_out into a 16-bit accumulator at the rising edge ending each address cycle, one word per cycle, wrapping modulo 2^16.
REQ-026 The SCAN accumulator SHALL be cleared when start is accepted.
REQ-027 checksum SHALL update only at SCAN completion.
REQ-028 Address wrap SHALL go from 511 to 0 with no error.
REQ-029 After the last access cycle, the block SHALL enter FIN for one cycle, pulse done, then return to IDLE.
REQ-030 Total latency from start accepted to done SHALL be count+1 cycles; an error command SHALL reach done in 1 cycle.
REQ-031 mem_load SHALL be 0 in IDLE and FIN.
REQ-032 After completion, mem_address SHALL hold its last value and mem_in SHALL hold its last value.
REQ-033 A start arriving in the same cycle as done SHALL be ignored; a new command is accepted only from IDLE.

Reset
REQ-034 rst_n=0 SHALL immediately, without waiting for a clock edge, force the following:
- state IDLE;
- busy, done, err and mem_load to 0;
- mem_in, mem_address and checksum to 0;
- the accumulator to 0.
REQ-035 Reset asserted mid-operation SHALL abort it, with no further RAM writes after assertion and no done pulse.
REQ-036 After rst_n rises, the block SHALL accept start on the first rising edge.

Verification
REQ-037 Fill-constant: mode=00, base=0, count=8, pattern=16'hA5A5 -> mem_load high 8 cycles, addresses 0..7, done at cycle 9, and RAM[0..7]=A5A5.
REQ-038 Fill-increment with wrap: mode=01, base=510, count=4, pattern=16'hFFFE -> addresses 510,511,0,1 with data FFFE,FFFF,0000,0001.
REQ-039 Scan-sum: after REQ-038, mode=10, base=510, count=4 -> checksum=16'hFFFE (sum mod 2^16) and done after 5 cycles.
REQ-040 Illegal commands: count=0, count=513 and mode=11 -> done and err pulse together 1 cycle after start, with mem_load never asserted.
REQ-041 Reset mid-fill: assert rst_n=0 in the 3rd fill cycle of count=16 -> mem_load drops immediately, busy=0, and only 2 or 3 words are written.
REQ-042 Busy start: pulse start with different arguments during a scan -> ignored, and checksum reflects the original command only.

Source files
------------

// File: rtl/ram512_seq.sv
// Sequencer that fills or checksums a region of an external 512-word RAM.
// Fill writes a constant or incrementing pattern; scan sums words into a 16-bit checksum.
module ram512_seq #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  input  logic [DATA_W-1:0] pattern,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum,
  output logic [DATA_W-1:0] mem_in,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(1 << ADDR_W);
  localparam logic [1:0] MODE_CONST = 2'b00;
  localparam logic [1:0] MODE_INC   = 2'b01;
  localparam logic [1:0] MODE_SCAN  = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  typedef enum logic [1:0] {IDLE, FILL, SCAN, FIN} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  remain, remain_d;
  logic              inc_q, inc_d;
  logic [DATA_W-1:0] acc, acc_d;
  logic [DATA_W-1:0] checksum_d, data_d, sum_c;
  logic [ADDR_W-1:0] addr_d;
  logic              load_d, busy_d, done_d, err_d;
  logic              legal_c;

  assign legal_c = (mode != MODE_RSVD) && (count != '0) && (count <= MAX_COUNT);
  assign sum_c   = acc + mem_out;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic; remain counts words still to go after the current one
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (!legal_c)               state_d = FIN;
          else if (mode == MODE_SCAN) state_d = SCAN;
          else                        state_d = FILL;
        end
      end
      FILL, SCAN: if (remain == '0) state_d = FIN;
      FIN:        state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs and datapath
  always_comb begin
    remain_d   = remain;
    inc_d      = inc_q;
    acc_d      = acc;
    checksum_d = checksum;
    addr_d     = mem_address;
    data_d     = mem_in;
    load_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          remain_d = count - CNT_W'(1);
          inc_d    = (mode == MODE_INC);
          acc_d    = '0;
          if (!legal_c) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            addr_d = base;
            if (mode == MODE_CONST || mode == MODE_INC) begin
              load_d = 1'b1;
              data_d = pattern;
            end
          end
        end
      end
      FILL: begin
        if (remain != '0) begin
          load_d   = 1'b1;
          addr_d   = mem_address + ADDR_W'(1);
          data_d   = inc_q ? mem_in + DATA_W'(1) : mem_in;
          remain_d = remain - CNT_W'(1);
        end else begin
          done_d = 1'b1;
        end
      end
      SCAN: begin
        acc_d = sum_c;
        if (remain != '0) begin
          addr_d   = mem_address + ADDR_W'(1);
          remain_d = remain - CNT_W'(1);
        end else begin
          done_d     = 1'b1;
          checksum_d = sum_c;
        end
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain      <= '0;
      inc_q       <= 1'b0;
      acc         <= '0;
      checksum    <= '0;
      mem_address <= '0;
      mem_in      <= '0;
      mem_load    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      remain      <= remain_d;
      inc_q       <= inc_d;
      acc         <= acc_d;
      checksum    <= checksum_d;
      mem_address <= addr_d;
      mem_in      <= data_d;
      mem_load    <= load_d;
      busy        <= busy_d;
      done        <= done_d;
      err         <= err_d;
    end
  end

endmodule

// File: tb/tb_ram512_seq.sv
// Bench for ram512_seq: behavioural RAM, per-cycle expectation queue, directed and random commands.
module tb_ram512_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic [8:0]  base;
  logic [9:0]  count;
  logic [15:0] pattern;
  logic        busy, done, err, mem_load;
  logic [15:0] checksum, mem_in, mem_out;
  logic [8:0]  mem_address;

  ram512_seq #(.DATA_W(16), .ADDR_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .base(base),
    .count(count), .pattern(pattern), .busy(busy), .done(done), .err(err),
    .checksum(checksum), .mem_in(mem_in), .mem_address(mem_address),
    .mem_load(mem_load), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  // Behavioural RAM, seeded from init_val on the first clock edge
  logic [15:0] init_val [512];
  logic [15:0] ram [512];
  logic        seeded = 1'b0;
  assign mem_out = ram[mem_address];
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 512; i++) ram[i] <= init_val[i];
      seeded <= 1'b1;
    end else if (mem_load) begin
      ram[mem_address] <= mem_in;
    end
  end

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        err;
    logic        load;
    logic [8:0]  addr;
    logic [15:0] data;
    logic [15:0] chk;
  } exp_t;

  exp_t        q [$];
  logic [15:0] ram_exp  [512];
  logic [15:0] ram_snap [512];
  logic [8:0]  m_addr = '0;
  logic [15:0] m_data = '0;
  logic [15:0] m_chk  = '0;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
  endtask

  function automatic exp_t mk(logic b, logic d, logic e, logic l,
                              logic [8:0] a, logic [15:0] dt, logic [15:0] ck);
    exp_t r;
    r.busy = b; r.done = d; r.err = e; r.load = l;
    r.addr = a; r.data = dt; r.chk = ck;
    return r;
  endfunction

  // Expected per-cycle outputs of one accepted command, from the command's meaning
  task automatic push_model(input int m, input int b, input int c, input int p, output int lat);
    logic [15:0] sum;
    int          a;
    if (m == 3 || c < 1 || c > 512) begin
      q.push_back(mk(1, 1, 1, 0, m_addr, m_data, m_chk));
      lat = 1;
      return;
    end
    sum = '0;
    for (int i = 0; i < c; i++) begin
      a = (b + i) % 512;
      if (m == 2) begin
        sum = sum + ram_exp[a];
        q.push_back(mk(1, 0, 0, 0, 9'(a), m_data, m_chk));
      end else begin
        m_data = (m == 0) ? 16'(p) : 16'(p + i);
        ram_exp[a] = m_data;
        q.push_back(mk(1, 0, 0, 1, 9'(a), m_data, m_chk));
      end
      m_addr = 9'(a);
    end
    if (m == 2) m_chk = sum;
    q.push_back(mk(1, 1, 0, 0, m_addr, m_data, m_chk));
    lat = c + 1;
  endtask

  // Single compare process: every cycle, DUT outputs against the model
  always @(negedge clk) begin : cmp
    exp_t e;
    if (!rst_n)              e = mk(0, 0, 0, 0, '0, '0, '0);
    else if (q.size() == 0)  e = mk(0, 0, 0, 0, m_addr, m_data, m_chk);
    else                     e = q.pop_front();
    check("cycle", 64'({busy, done, err, mem_load, mem_address, mem_in, checksum}), 64'(e));
  end

  // Issue a command; optionally pulse another start on cycle poke_at (must be ignored)
  task automatic issue(input int m, input int b, input int c, input int p,
                       input int poke_at, output int lat);
    int exp_lat;
    @(negedge clk);
    mode = 2'(m); base = 9'(b); count = 10'(c); pattern = 16'(p); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    push_model(m, b, c, p, exp_lat);
    lat = -1;
    for (int k = 1; k <= 1100; k++) begin
      @(negedge clk);
      if (k == poke_at) begin
        mode = 2'($urandom_range(0, 2)); base = 9'($urandom); count = 10'($urandom_range(1, 20));
        pattern = 16'($urandom); start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    if (start) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
    if (lat < 0) q.delete();
    check("latency", 64'(lat), 64'(exp_lat));
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int lat, m, b, c, sel, poke, bad;
    start = 1'b0; mode = '0; base = '0; count = '0; pattern = '0; rst_n = 1'b0;
    for (int i = 0; i < 512; i++) begin
      init_val[i] = 16'($urandom);
      ram_exp[i]  = init_val[i];
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Fill-constant at address 0
    issue(0, 0, 8, 'hA5A5, 0, lat);
    check("fill_const_latency", 64'(lat), 64'd9);
    for (int i = 0; i < 8; i++) check("fill_const_ram", 64'(ram[i]), 64'h0000_0000_0000_A5A5);

    // Fill-increment across the 511->0 wrap
    issue(1, 510, 4, 'hFFFE, 0, lat);
    check("fill_inc_510", 64'(ram[510]), 64'hFFFE);
    check("fill_inc_511", 64'(ram[511]), 64'hFFFF);
    check("fill_inc_0",   64'(ram[0]),   64'h0000);
    check("fill_inc_1",   64'(ram[1]),   64'h0001);

    // Scan with a start pulse mid-operation, then one coincident with done
    issue(2, 510, 4, 0, 2, lat);
    check("scan_latency", 64'(lat), 64'd5);
    check("scan_checksum", 64'(checksum), 64'hFFFE);
    issue(2, 510, 4, 0, 5, lat);
    check("scan_hold_checksum", 64'(checksum), 64'hFFFE);

    // Illegal commands
    issue(0, 10, 0, 'h1111, 0, lat);
    check("err_count0_latency", 64'(lat), 64'd1);
    issue(1, 10, 513, 'h2222, 0, lat);
    check("err_count513_latency", 64'(lat), 64'd1);
    issue(3, 10, 5, 'h3333, 0, lat);
    check("err_mode3_latency", 64'(lat), 64'd1);

    // Reset in the third cycle of a 16-word fill
    ram_snap = ram_exp;
    @(negedge clk);
    mode = 2'd1; base = 9'd200; count = 10'd16; pattern = 16'h0100; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    push_model(1, 200, 16, 'h0100, lat);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    m_addr = '0; m_data = '0; m_chk = '0;
    ram_exp = ram_snap;
    ram_exp[200] = 16'h0100;
    ram_exp[201] = 16'h0101;
    #1 check("reset_async", 64'({busy, done, err, mem_load, mem_address, mem_in, checksum}), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    check("reset_word0", 64'(ram[200]), 64'h0100);
    check("reset_word1", 64'(ram[201]), 64'h0101);
    check("reset_word2", 64'(ram[202]), 64'(ram_snap[202]));
    issue(2, 200, 3, 0, 0, lat);
    check("restart_latency", 64'(lat), 64'd4);

    // Random commands
    for (int n = 0; n < 40; n++) begin
      m   = $urandom_range(0, 3);
      b   = $urandom_range(0, 511);
      sel = $urandom_range(0, 9);
      c   = (sel == 0) ? 0 : (sel == 1) ? 512 : (sel == 2) ? $urandom_range(513, 1023)
                                                         : $urandom_range(1, 40);
      poke = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      issue(m, b, c, $urandom, poke, lat);
    end

    // Whole-RAM fill and scan
    issue(1, 300, 512, $urandom, 0, lat);
    issue(2, 17, 512, 0, 0, lat);

    repeat (2) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 512; i++) if (ram[i] !== ram_exp[i]) bad++;
    check("ram_image_bad_words", 64'(bad), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
